// File: rtl/sysid_checker.sv
// sysid_checker: boot-time Avalon-MM reader of the system-ID slave.
// Reads the ID word (address 0) and the timestamp word (address 1),
// compares them with build-time values and reports a held pass/fail
// result plus a one-cycle done pulse. Every output is registered.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd11,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1447922295,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  // Zero means the timeout is disabled.
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ_ID = 2'd1,
    S_READ_TS = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   stall_cnt, stall_cnt_nxt;
  logic               auto_pending, auto_pending_nxt;

  logic               read_nxt, addr_nxt, busy_nxt, done_nxt;
  logic               pass_nxt, id_mis_nxt, ts_mis_nxt, timeout_nxt;
  logic [DATA_W-1:0]  id_val_nxt, ts_val_nxt;

  // The current stall cycle is the one that exhausts the per-read budget.
  function automatic logic stall_expired(input logic [CNT_W-1:0] cnt);
    return (TIMEOUT_LIM != '0) &&
           (({1'b0, cnt} + (CNT_W+1)'(1)) == TIMEOUT_LIM);
  endfunction

  // Stall counter saturates so an unbounded stall with timeout disabled
  // can never wrap back to a small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Next-state, next-result and next-output decode
  always_comb begin
    state_nxt        = state;
    stall_cnt_nxt    = stall_cnt;
    auto_pending_nxt = auto_pending;
    pass_nxt         = pass;
    id_mis_nxt       = id_mismatch;
    ts_mis_nxt       = ts_mismatch;
    timeout_nxt      = timeout;
    id_val_nxt       = id_value;
    ts_val_nxt       = ts_value;

    case (state)
      S_IDLE: begin
        if (start || auto_pending) begin
          state_nxt        = S_READ_ID;
          stall_cnt_nxt    = '0;
          auto_pending_nxt = 1'b0;
          pass_nxt         = 1'b0;
          id_mis_nxt       = 1'b0;
          ts_mis_nxt       = 1'b0;
          timeout_nxt      = 1'b0;
          id_val_nxt       = '0;
          ts_val_nxt       = '0;
        end
      end
      S_READ_ID: begin
        if (!avm_waitrequest) begin
          id_val_nxt    = avm_readdata;
          id_mis_nxt    = (avm_readdata != EXPECTED_ID);
          state_nxt     = S_READ_TS;
          stall_cnt_nxt = '0;
        end else if (stall_expired(stall_cnt)) begin
          timeout_nxt   = 1'b1;
          state_nxt     = S_DONE;
          stall_cnt_nxt = '0;
        end else begin
          stall_cnt_nxt = sat_inc(stall_cnt);
        end
      end
      S_READ_TS: begin
        if (!avm_waitrequest) begin
          ts_val_nxt    = avm_readdata;
          ts_mis_nxt    = CHECK_TIMESTAMP && (avm_readdata != EXPECTED_TIMESTAMP);
          state_nxt     = S_DONE;
          stall_cnt_nxt = '0;
        end else if (stall_expired(stall_cnt)) begin
          timeout_nxt   = 1'b1;
          state_nxt     = S_DONE;
          stall_cnt_nxt = '0;
        end else begin
          stall_cnt_nxt = sat_inc(stall_cnt);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // DONE is only ever entered from a read state, so pass settles once.
    if (state_nxt == S_DONE) begin
      pass_nxt = !id_mis_nxt && !ts_mis_nxt && !timeout_nxt;
    end

    read_nxt = (state_nxt == S_READ_ID) || (state_nxt == S_READ_TS);
    addr_nxt = (state_nxt == S_READ_TS);
    busy_nxt = read_nxt;
    done_nxt = (state_nxt == S_DONE);
  end

  // State register, stall counter and auto-start request
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      stall_cnt    <= '0;
      auto_pending <= AUTO_START;
    end else begin
      state        <= state_nxt;
      stall_cnt    <= stall_cnt_nxt;
      auto_pending <= auto_pending_nxt;
    end
  end

  // Registered bus strobes, status and captured result words
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      avm_read    <= read_nxt;
      avm_address <= addr_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
      id_mismatch <= id_mis_nxt;
      ts_mismatch <= ts_mis_nxt;
      timeout     <= timeout_nxt;
      id_value    <= id_val_nxt;
      ts_value    <= ts_val_nxt;
    end
  end

endmodule
